// File: rtl/uart_apb_stream_master.sv
// uart_apb_stream_master: APB3 master that configures a CoreUARTapb once and then
// bridges its TX/RX data registers to valid/ready byte streams by status polling.
module uart_apb_stream_master #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        PRG_BIT8   = 1'b1,
    parameter logic [1:0]  PRG_PARITY = 2'b00,
    parameter logic        INIT_EN    = 1'b1,
    parameter int          POLL_GAP   = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic [2:0] rx_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       apb_err,
    input  logic       err_clr
);
    typedef enum logic [2:0] {INIT1, INIT2, POLL, TXWR, RXRD, GAP} state_t;
    localparam state_t     RST_STATE = INIT_EN ? INIT1 : POLL;
    localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);

    state_t     r_state, w_state_nx;
    logic       r_psel, r_penable, r_pwrite, w_pwrite, w_done, w_start;
    logic [4:0] r_paddr, w_paddr;
    logic [7:0] r_pwdata, w_pwdata, r_cnt, r_tx_buf, r_rx_data;
    logic       r_tx_full, r_rx_full, r_apb_err;
    logic [2:0] r_rx_err, r_err_pend;

    assign w_done = r_psel && r_penable && PREADY;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            INIT1:      w_state_nx = w_done ? INIT2 : INIT1;
            INIT2:      w_state_nx = w_done ? POLL : INIT2;
            // RX wins over TX so the UART receive FIFO drains first
            POLL:       if (w_done) w_state_nx = (PRDATA[1] && !r_rx_full) ? RXRD :
                                                 (PRDATA[0] && r_tx_full) ? TXWR :
                                                 (POLL_GAP == 0) ? POLL : GAP;
            TXWR, RXRD: w_state_nx = w_done ? POLL : r_state;
            GAP:        w_state_nx = (r_cnt == GAP_LAST) ? POLL : GAP;
            default:    w_state_nx = RST_STATE;
        endcase
        // A new SETUP begins on completion (back-to-back) or from idle into a transfer state
        w_start  = (w_state_nx != GAP) && (w_done || !r_psel);
        w_paddr  = (w_state_nx == INIT1) ? 5'h08 : (w_state_nx == INIT2) ? 5'h0C :
                   (w_state_nx == TXWR) ? 5'h00 : (w_state_nx == RXRD) ? 5'h04 : 5'h10;
        w_pwrite = w_state_nx inside {INIT1, INIT2, TXWR};
        w_pwdata = (w_state_nx == INIT1) ? BAUD_VALUE[7:0] :
                   (w_state_nx == INIT2) ? {BAUD_VALUE[12:8], PRG_PARITY, PRG_BIT8} :
                   (w_state_nx == TXWR) ? r_tx_buf : 8'h00;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) r_state <= RST_STATE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= 5'h00;
            r_pwdata   <= 8'h00;
            r_cnt      <= 8'h00;
            r_tx_full  <= 1'b0;
            r_tx_buf   <= 8'h00;
            r_rx_full  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_err   <= 3'b000;
            r_err_pend <= 3'b000;
            r_apb_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_paddr   <= w_paddr;
                r_pwrite  <= w_pwrite;
                r_pwdata  <= w_pwdata;
            end else if (w_done) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end else if (r_psel) begin
                r_penable <= 1'b1;
            end
            r_cnt <= (r_state == GAP) ? r_cnt + 8'd1 : 8'h00;
            if (w_done && r_state == TXWR) begin
                r_tx_full <= 1'b0;
            end else if (tx_valid && !r_tx_full) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= tx_data;
            end
            if (w_done && r_state == RXRD) begin
                r_rx_full <= 1'b1;
                r_rx_data <= PRDATA;
                r_rx_err  <= r_err_pend;
            end else if (r_rx_full && rx_ready) begin
                r_rx_full <= 1'b0;
            end
            if (w_done && r_state == POLL)      r_err_pend <= PRDATA[4:2];
            else if (w_done && r_state == RXRD) r_err_pend <= 3'b000;
            if (w_done && PSLVERR) r_apb_err <= 1'b1;
            else if (err_clr)      r_apb_err <= 1'b0;
        end
    end

    assign PSEL     = r_psel;
    assign PENABLE  = r_penable;
    assign PWRITE   = r_pwrite;
    assign PADDR    = r_paddr;
    assign PWDATA   = r_pwdata;
    assign tx_ready = !r_tx_full;
    assign rx_valid = r_rx_full;
    assign rx_data  = r_rx_data;
    assign rx_err   = r_rx_err;
    assign apb_err  = r_apb_err;
endmodule

// File: tb/tb_uart_apb_stream_master.sv
// tb_uart_apb_stream_master: drives the master against a behavioural UART slave with
// queues for pending TX bytes, the UART receive FIFO and bytes owed on the RX stream.
module tb_uart_apb_stream_master;
    localparam int GAP = 4;

    logic       PCLK = 1'b0, PRESETN = 1'b0;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b0, PSLVERR = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rx_valid, rx_ready = 1'b0;
    logic       apb_err, err_clr = 1'b0;

    uart_apb_stream_master #(
        .BAUD_VALUE(13'h1A5), .PRG_BIT8(1'b1), .PRG_PARITY(2'b11), .INIT_EN(1'b1), .POLL_GAP(GAP)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready), .apb_err(apb_err),
        .err_clr(err_clr)
    );

    initial forever #5 PCLK = ~PCLK;

    int n_chk = 0, n_pass = 0;
    int wait_max = 0, tx_pct = 0, rx_pct = 100, arr_pct = 0, err_pct = 0, clr_pct = 0;
    int txrdy_mode = 1, force_wait = -1;
    bit force_err = 0, clr_req = 0, m_apb_err = 0, tx_hs = 0, s_err = 0, found = 0;
    int exp_gap = -1, idle = 0, waits = 0, acc = 0, s_waits = 0;
    logic [4:0] exp_addr = 5'h08, s_addr = 5'h00;
    logic       s_wr = 1'b0;
    logic [7:0] s_wd = 8'h00;
    logic [7:0]  tx_exp[$], tx_src[$];
    logic [10:0] rx_exp[$], fifo[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Slave side of a completing transfer; also predicts the next transfer the master must start
    task automatic apb_done();
        logic [10:0] e;
        logic rxr, txr;
        chk("paddr_stable", PADDR, s_addr);
        chk("pwrite_stable", PWRITE, s_wr);
        chk("pwdata_stable", PWDATA, s_wd);
        chk("access_len", acc, s_waits + 1);
        exp_gap = 0;
        exp_addr = 5'h10;
        case (s_addr)
            5'h08: begin chk("ctrl1", PWDATA, 8'hA5); exp_addr = 5'h0C; end
            5'h0C: chk("ctrl2", PWDATA, 8'h0F);
            5'h00: begin
                chk("tx_pending", tx_exp.size() != 0, 1);
                if (tx_exp.size() != 0) chk("tx_byte", PWDATA, tx_exp.pop_front());
            end
            5'h04: begin
                chk("rx_avail", fifo.size() != 0, 1);
                e = 11'h0;
                if (fifo.size() != 0) e = fifo.pop_front();
                PRDATA = e[7:0];
                rx_exp.push_back(e);
            end
            default: begin
                rxr = fifo.size() != 0;
                txr = (txrdy_mode == 1) ? 1'b1 : (txrdy_mode == 2) ? 1'b0 : ($urandom_range(3, 0) != 0);
                e = rxr ? fifo[0] : 11'h0;
                PRDATA = {3'b000, e[10:8], rxr, txr};
                if (rxr && rx_exp.size() == 0)      exp_addr = 5'h04;
                else if (txr && tx_exp.size() != 0) exp_addr = 5'h00;
                else exp_gap = GAP;
            end
        endcase
    endtask

    task automatic tick();
        logic [10:0] e;
        logic serr;
        @(negedge PCLK);
        PSLVERR = 1'b0;
        PRDATA = 8'($urandom);
        err_clr = 1'b0;
        serr = 1'b0;
        if (!PRESETN) begin
            chk("rst_psel", PSEL, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_pwrite", PWRITE, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_tx_ready", tx_ready, 1);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_rx_err", rx_err, 0);
            chk("rst_apb_err", apb_err, 0);
            tx_exp.delete(); rx_exp.delete(); fifo.delete(); tx_src.delete();
            m_apb_err = 0; exp_addr = 5'h08; exp_gap = -1; idle = 0; acc = 0;
            tx_valid = 1'b0; tx_hs = 0; rx_ready = 1'b0; PREADY = 1'b0;
            return;
        end
        chk("tx_ready", tx_ready, tx_exp.size() == 0);
        chk("rx_valid", rx_valid, rx_exp.size() != 0);
        chk("apb_err", apb_err, m_apb_err);
        if (!PSEL) idle++;
        if (PSEL && !PENABLE) begin
            if (exp_gap >= 0) chk("idle_gap", idle, exp_gap);
            chk("paddr", PADDR, exp_addr);
            chk("pwrite", PWRITE, exp_addr inside {5'h00, 5'h08, 5'h0C});
            s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA;
            s_err = force_err; force_err = 0;
            s_waits = (force_wait >= 0) ? force_wait : int'($urandom_range(wait_max, 0));
            force_wait = -1; waits = s_waits; acc = 0; idle = 0;
        end
        PREADY = 1'($urandom_range(1, 0));
        if (PSEL && PENABLE) begin
            acc++;
            PREADY = (waits == 0);
            if (waits != 0) waits--;
            else begin
                serr = s_err || ($urandom_range(99, 0) < err_pct);
                PSLVERR = serr;
                apb_done();
            end
        end
        if (clr_req || ($urandom_range(99, 0) < clr_pct)) begin err_clr = 1'b1; clr_req = 0; end
        m_apb_err = serr ? 1'b1 : err_clr ? 1'b0 : m_apb_err;
        if (tx_hs) tx_valid = 1'b0;
        if (!tx_valid && tx_src.size() != 0) begin
            tx_valid = 1'b1; tx_data = tx_src.pop_front();
        end else if (!tx_valid && $urandom_range(99, 0) < tx_pct) begin
            tx_valid = 1'b1; tx_data = 8'($urandom);
        end
        tx_hs = tx_valid && tx_ready;
        if (tx_hs) tx_exp.push_back(tx_data);
        rx_ready = ($urandom_range(99, 0) < rx_pct);
        if (rx_valid && rx_ready && rx_exp.size() != 0) begin
            e = rx_exp.pop_front();
            chk("rx_data", rx_data, e[7:0]);
            chk("rx_err", rx_err, e[10:8]);
        end
        if (fifo.size() < 4 && $urandom_range(99, 0) < arr_pct)
            fifo.push_back({($urandom_range(4, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'd0, 8'($urandom)});
    endtask

    task automatic do_release();
        @(posedge PCLK);
        #1 PRESETN = 1'b1;
        @(posedge PCLK);
        #1;
        chk("first_psel", PSEL, 1);
        chk("first_penable", PENABLE, 0);
        chk("first_paddr", PADDR, 5'h08);
    endtask

    initial begin
        repeat (3) tick();
        do_release();
        repeat (40) tick();
        tx_src.push_back(8'h55);
        repeat (20) tick();
        fifo.push_back({3'b000, 8'hC3});
        tx_src.push_back(8'hAA);
        repeat (40) tick();
        txrdy_mode = 2; rx_pct = 0;
        fifo.push_back({3'b110, 8'h3C});
        fifo.push_back({3'b000, 8'h77});
        repeat (60) tick();
        chk("rx_held", rx_valid, 1);
        chk("rx_held_err", rx_err, 3'b110);
        chk("rx_held_data", rx_data, 8'h3C);
        rx_pct = 100;
        repeat (40) tick();
        txrdy_mode = 1; force_wait = 3; force_err = 1;
        repeat (20) tick();
        chk("apb_err_sticky", apb_err, 1);
        clr_req = 1;
        repeat (3) tick();
        chk("apb_err_cleared", apb_err, 0);
        wait_max = 3;
        tx_src.push_back(8'h99);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = PSEL && PENABLE && PWRITE && PADDR == 5'h00;
        end
        chk("txwr_seen", found, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("async_psel", PSEL, 0);
        chk("async_penable", PENABLE, 0);
        repeat (2) tick();
        wait_max = 0;
        do_release();
        repeat (20) tick();
        wait_max = 2; tx_pct = 30; arr_pct = 20; rx_pct = 60; err_pct = 3; clr_pct = 2; txrdy_mode = 0;
        repeat (3000) tick();
        tx_pct = 0; arr_pct = 0; rx_pct = 100; err_pct = 0; txrdy_mode = 1;
        repeat (300) tick();
        chk("drain_tx", tx_exp.size(), 0);
        chk("drain_rx", rx_exp.size(), 0);
        chk("drain_fifo", fifo.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
